button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//  Turns a raw, bouncing, asynchronous push-button into clean single-cycle events.
//  It is the producer side of the timer_switch btn input: press drives timer_switch.btn directly.
//  It also provides a debounced level, a release pulse and a one-shot long-press pulse for panel logic.
// PARAMETERS
//  DEBOUNCE_CYCLES    4   consecutive stable synchronized samples needed to accept a press or release; >=1
//  LONG_PRESS_CYCLES  20  edges spent in HELD/RELEASE_WAIT before long_press fires; >=1
// PORTS
//  clock       in   1  single clock, all logic on posedge
//  reset       in   1  synchronous, active-high
//  btn_raw     in   1  raw button, asynchronous, may bounce
//  pressed     out  1  debounced level: 1 in HELD and RELEASE_WAIT
//  press       out  1  one-cycle pulse on an accepted press; connects to timer_switch.btn
//  release_p   out  1  one-cycle pulse on an accepted release
//  long_press  out  1  one-cycle pulse, at most once per accepted press
// BEHAVIOUR
//  - Reset: sampled at a posedge, it forces state=IDLE, counters=0, sync FFs=0, all outputs 0 from the next cycle.
//  - Reset mid-press: emits no release_p or long_press; it overrides everything on that edge.
//  - Synchronizer: 2 FF stages; btn_sync = stage 2. Edge k=0 is the first posedge sampling btn_raw=1.
//  - btn_sync is 1 from edge k=1 onward; the FSM first sees it at edge k=2.
//  - States:
//    - IDLE: btn_sync=1 -> PRESS_WAIT, deb_cnt=1.
//    - PRESS_WAIT: btn_sync=0 -> IDLE, deb_cnt=0 (bounce rejected, no output).
//      btn_sync=1 -> deb_cnt++. When this edge is the DEBOUNCE_CYCLES-th consecutive 1 sample -> HELD,
//      press=1 for the next cycle, hold_cnt=0. DEBOUNCE_CYCLES=1 goes IDLE->HELD directly.
//    - HELD: btn_sync=1 -> hold_cnt++ (saturating). btn_sync=0 -> RELEASE_WAIT, deb_cnt=1.
//    - RELEASE_WAIT: btn_sync=1 -> HELD, deb_cnt=0, no pulse; hold_cnt retained and keeps counting.
//      btn_sync=0 -> deb_cnt++. On the DEBOUNCE_CYCLES-th consecutive 0 sample -> IDLE, release_p=1 next cycle.
//  - Press latency: press is high in the cycle after edge k=DEBOUNCE_CYCLES+1 (default: after edge 5).
//  - Release latency: same relative to the first posedge sampling btn_raw=0.
//  - long_press: fires when hold_cnt reaches LONG_PRESS_CYCLES-1, i.e. the LONG_PRESS_CYCLES-th edge
//    after entering HELD. hold_cnt increments in both HELD and RELEASE_WAIT. Fires once per press,
//    guarded by a fired flag cleared on entry to IDLE.
//  - If release is accepted on the same edge long_press would fire, both pulses assert in the same cycle.
//  - pressed: registered, rises in the same cycle as press and falls in the same cycle as release_p.
//  - All outputs are registered; press, release_p and long_press are never high for 2 consecutive cycles.
//  - Counter width CW = $clog2(max(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES)+1).
//  - Counters saturate and never wrap; no output event is caused by counter overflow.
// STRUCTURE
//  - button_pkg: typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} btn_state_t;
//    plus a function for counter width.
//  - Sub-module sync_2ff (parameterless 2-FF synchronizer, reset to 0); the rest is one FSM + counters.
// TESTING (D=4, L=20, clock period T=20)
//  - reset=1 for 1 cycle, btn_raw=0 -> next cycle state==IDLE; pressed, press, release_p, long_press all 0.
//  - btn_raw 0->1 held 10 cycles -> press=1 exactly in the cycle after edge 5; pressed=1 from then on.
//  - Bounce: btn_raw toggles 1,0,1,0,1 at 1-cycle spacing then 0 -> no press, state returns to IDLE.
//  - Hold 30 cycles then release -> long_press once, 20 edges after entering HELD.
//    Then release_p once, 5 edges after btn_raw falls; pressed falls with release_p.
//  - Release glitch: 2-cycle 0 dip while HELD -> no release_p, no second press, long_press still once.
//  - Reset asserted while HELD at hold_cnt=10 -> all outputs 0 next cycle, no release_p or long_press emitted.
//  - Integration with timer_switch: press -> light=1 the next cycle; light stays on 20 cycles
//    after the last press.
//  - Assertions: $rose(press) |=> !press; press |-> pressed; release_p |-> !pressed.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and helpers for the push-button conditioner.
package button_pkg;

  // Debounce / hold FSM states.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  // Width needed to count up to the larger of the two cycle limits.
  function automatic int cnt_width(input int debounce_cycles, input int long_press_cycles);
    int m;
    m = (debounce_cycles > long_press_cycles) ? debounce_cycles : long_press_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchronizer bringing an asynchronous level into the clock domain.
module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic stage1_q;
  logic stage2_q;

  // Shift the raw level through two flops; both clear on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      stage1_q <= 1'b0;
      stage2_q <= 1'b0;
    end else begin
      stage1_q <= d;
      stage2_q <= stage1_q;
    end
  end

  assign q = stage2_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounces a raw push-button and produces a clean level plus press,
// release and one-shot long-press pulses. All outputs are registered.
module button_conditioner
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 4,
  parameter int LONG_PRESS_CYCLES = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic pressed,
  output logic press,
  output logic release_p,
  output logic long_press
);

  localparam int            CW        = cnt_width(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_PRESS_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

  logic btn_sync;

  btn_state_t    state_q,      state_d;
  logic [CW-1:0] deb_cnt_q,    deb_cnt_d;
  logic [CW-1:0] hold_cnt_q,   hold_cnt_d;
  logic          fired_q,      fired_d;
  logic          pressed_q,    pressed_d;
  logic          press_q,      press_d;
  logic          release_q,    release_d;
  logic          long_q,       long_d;

  // Counters stop at all-ones so they can never wrap into a false event.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  sync_2ff u_sync (
    .clock (clock),
    .reset (reset),
    .d     (btn_raw),
    .q     (btn_sync)
  );

  // Next-state, counter and pulse logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    deb_cnt_d  = deb_cnt_q;
    hold_cnt_d = hold_cnt_q;
    fired_d    = fired_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;

    // Hold time accumulates across release glitches; long press fires once.
    if (state_q == HELD || state_q == RELEASE_WAIT) begin
      hold_cnt_d = sat_inc(hold_cnt_q);
      if (!fired_q && hold_cnt_q >= LONG_LAST) begin
        long_d  = 1'b1;
        fired_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (btn_sync) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d    = HELD;
            press_d    = 1'b1;
            hold_cnt_d = '0;
            deb_cnt_d  = '0;
          end else begin
            state_d   = PRESS_WAIT;
            deb_cnt_d = CW'(1);
          end
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync) begin
          state_d   = IDLE;
          deb_cnt_d = '0;
        end else if (deb_cnt_q >= DEB_LAST) begin
          state_d    = HELD;
          press_d    = 1'b1;
          hold_cnt_d = '0;
          deb_cnt_d  = '0;
        end else begin
          deb_cnt_d = sat_inc(deb_cnt_q);
        end
      end
      HELD: begin
        if (!btn_sync) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d   = IDLE;
            release_d = 1'b1;
            deb_cnt_d = '0;
          end else begin
            state_d   = RELEASE_WAIT;
            deb_cnt_d = CW'(1);
          end
        end
      end
      RELEASE_WAIT: begin
        if (btn_sync) begin
          state_d   = HELD;
          deb_cnt_d = '0;
        end else if (deb_cnt_q >= DEB_LAST) begin
          state_d   = IDLE;
          release_d = 1'b1;
          deb_cnt_d = '0;
        end else begin
          deb_cnt_d = sat_inc(deb_cnt_q);
        end
      end
      default: begin
        state_d   = IDLE;
        deb_cnt_d = '0;
      end
    endcase

    // Returning to IDLE re-arms the long-press one-shot.
    if (state_d == IDLE) begin
      hold_cnt_d = '0;
      fired_d    = 1'b0;
    end

    pressed_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q    <= IDLE;
      deb_cnt_q  <= '0;
      hold_cnt_q <= '0;
      fired_q    <= 1'b0;
      pressed_q  <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      deb_cnt_q  <= deb_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      fired_q    <= fired_d;
      pressed_q  <= pressed_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
    end
  end

  assign pressed    = pressed_q;
  assign press      = press_q;
  assign release_p  = release_q;
  assign long_press = long_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner (D=4, L=20, T=20).
// Expected output events are queued when stimulus is driven and matched
// against observed events as the DUT produces them.
module tb_button_conditioner;
  import button_pkg::*;

  typedef enum int {EV_PRESS, EV_RISE, EV_LONG, EV_RELEASE, EV_FALL} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       at_edge;
  } exp_ev_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic btn_raw = 1'b0;
  logic pressed, press, release_p, long_press;

  int      n_checks = 0;
  int      n_fail   = 0;
  int      edge_cnt = 0;
  exp_ev_t exp_q[$];
  exp_ev_t mon_e;
  ev_kind_t seen[$];
  bit      pressed_prev = 1'b0;

  button_conditioner #(
    .DEBOUNCE_CYCLES   (4),
    .LONG_PRESS_CYCLES (20)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .pressed    (pressed),
    .press      (press),
    .release_p  (release_p),
    .long_press (long_press)
  );

  always #10 clock = ~clock;

  // Index of the most recent posedge.
  always @(posedge clock) edge_cnt = edge_cnt + 1;

  // Scoreboard: every observed event must match the head of the expected queue.
  always @(negedge clock) begin
    seen.delete();
    if (press === 1'b1)                   seen.push_back(EV_PRESS);
    if (pressed === 1'b1 && !pressed_prev) seen.push_back(EV_RISE);
    if (long_press === 1'b1)              seen.push_back(EV_LONG);
    if (release_p === 1'b1)               seen.push_back(EV_RELEASE);
    if (pressed !== 1'b1 && pressed_prev)  seen.push_back(EV_FALL);
    pressed_prev = (pressed === 1'b1);
    foreach (seen[i]) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard: got %s at edge %0d, required no event", seen[i].name(), edge_cnt);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.kind != seen[i] || mon_e.at_edge != edge_cnt) begin
          n_fail++;
          $display("FAIL scoreboard: got %s at edge %0d, required %s at edge %0d",
                   seen[i].name(), edge_cnt, mon_e.kind.name(), mon_e.at_edge);
        end
      end
    end
  end

  // Protocol properties on the pulse outputs.
  assert property (@(posedge clock) disable iff (reset) $rose(press) |=> !press)
    else begin n_fail++; $display("FAIL prop_press_single: press high 2 cycles"); end
  assert property (@(posedge clock) disable iff (reset) press |-> pressed)
    else begin n_fail++; $display("FAIL prop_press_level: press=1 with pressed=0"); end
  assert property (@(posedge clock) disable iff (reset) release_p |-> !pressed)
    else begin n_fail++; $display("FAIL prop_release_level: release_p=1 with pressed=1"); end

  // Drive a level starting at this negedge for n cycles; k is the first sampling edge.
  task automatic drive(input logic v, input int n, output int k);
    btn_raw = v;
    k = edge_cnt + 1;
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    btn_raw = 1'b0;
    @(negedge clock);
    n_checks++;
    if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d required %0d", dut.state_q, IDLE); end
    n_checks++;
    if (pressed !== 1'b0) begin n_fail++; $display("FAIL reset_pressed: got %b required 0", pressed); end
    n_checks++;
    if (press !== 1'b0) begin n_fail++; $display("FAIL reset_press: got %b required 0", press); end
    n_checks++;
    if (release_p !== 1'b0) begin n_fail++; $display("FAIL reset_release: got %b required 0", release_p); end
    n_checks++;
    if (long_press !== 1'b0) begin n_fail++; $display("FAIL reset_long: got %b required 0", long_press); end
    reset = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_press();
    int k0, r0;
    btn_raw = 1'b1;
    k0 = edge_cnt + 1;
    exp_q.push_back('{EV_PRESS, k0 + 5});
    exp_q.push_back('{EV_RISE,  k0 + 5});
    repeat (5) @(negedge clock);
    n_checks++;
    if (press !== 1'b0) begin n_fail++; $display("FAIL press_early: got %b required 0", press); end
    @(negedge clock);
    n_checks++;
    if (press !== 1'b1) begin n_fail++; $display("FAIL press_latency: got %b required 1", press); end
    n_checks++;
    if (pressed !== 1'b1) begin n_fail++; $display("FAIL press_level: got %b required 1", pressed); end
    @(negedge clock);
    n_checks++;
    if (press !== 1'b0) begin n_fail++; $display("FAIL press_width: got %b required 0", press); end
    n_checks++;
    if (pressed !== 1'b1) begin n_fail++; $display("FAIL press_level_hold: got %b required 1", pressed); end
    repeat (3) @(negedge clock);
    btn_raw = 1'b0;
    r0 = edge_cnt + 1;
    exp_q.push_back('{EV_RELEASE, r0 + 5});
    exp_q.push_back('{EV_FALL,    r0 + 5});
    repeat (10) @(negedge clock);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL press_missing: got %0d pending events required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_bounce();
    logic pat [6];
    int k;
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) drive(pat[i], 1, k);
    drive(1'b0, 10, k);
    n_checks++;
    if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL bounce_state: got %0d required %0d", dut.state_q, IDLE); end
    n_checks++;
    if (pressed !== 1'b0) begin n_fail++; $display("FAIL bounce_pressed: got %b required 0", pressed); end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL bounce_pending: got %0d required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_long_press();
    int k0, r0;
    k0 = edge_cnt + 1;
    exp_q.push_back('{EV_PRESS,   k0 + 5});
    exp_q.push_back('{EV_RISE,    k0 + 5});
    exp_q.push_back('{EV_LONG,    k0 + 25});
    exp_q.push_back('{EV_RELEASE, k0 + 35});
    exp_q.push_back('{EV_FALL,    k0 + 35});
    drive(1'b1, 30, k0);
    drive(1'b0, 10, r0);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL long_missing: got %0d pending events required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_glitch();
    int k0, k;
    k0 = edge_cnt + 1;
    exp_q.push_back('{EV_PRESS,   k0 + 5});
    exp_q.push_back('{EV_RISE,    k0 + 5});
    exp_q.push_back('{EV_LONG,    k0 + 25});
    exp_q.push_back('{EV_RELEASE, k0 + 47});
    exp_q.push_back('{EV_FALL,    k0 + 47});
    drive(1'b1, 10, k);
    drive(1'b0, 2, k);
    drive(1'b1, 30, k);
    drive(1'b0, 10, k);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL glitch_missing: got %0d pending events required 0", exp_q.size()); exp_q.delete(); end
  endtask

  // Release accepted on the long-press edge, then one edge too early for it.
  task automatic test_release_on_long_edge();
    int k0, k;
    k0 = edge_cnt + 1;
    exp_q.push_back('{EV_PRESS,   k0 + 5});
    exp_q.push_back('{EV_RISE,    k0 + 5});
    exp_q.push_back('{EV_LONG,    k0 + 25});
    exp_q.push_back('{EV_RELEASE, k0 + 25});
    exp_q.push_back('{EV_FALL,    k0 + 25});
    drive(1'b1, 20, k);
    drive(1'b0, 10, k);
    k0 = edge_cnt + 1;
    exp_q.push_back('{EV_PRESS,   k0 + 5});
    exp_q.push_back('{EV_RISE,    k0 + 5});
    exp_q.push_back('{EV_RELEASE, k0 + 24});
    exp_q.push_back('{EV_FALL,    k0 + 24});
    drive(1'b1, 19, k);
    drive(1'b0, 10, k);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL coincide_missing: got %0d pending events required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_reset_mid_press();
    int k0;
    k0 = edge_cnt + 1;
    exp_q.push_back('{EV_PRESS, k0 + 5});
    exp_q.push_back('{EV_RISE,  k0 + 5});
    drive(1'b1, 16, k0);
    n_checks++;
    if (dut.hold_cnt_q !== 5'd10) begin n_fail++; $display("FAIL midreset_hold: got %0d required 10", dut.hold_cnt_q); end
    reset = 1'b1;
    btn_raw = 1'b0;
    exp_q.push_back('{EV_FALL, edge_cnt + 1});
    @(negedge clock);
    reset = 1'b0;
    n_checks++;
    if ({pressed, press, release_p, long_press} !== 4'b0000)
      begin n_fail++; $display("FAIL midreset_outputs: got %b required 0000", {pressed, press, release_p, long_press}); end
    n_checks++;
    if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL midreset_state: got %0d required %0d", dut.state_q, IDLE); end
    repeat (30) @(negedge clock);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL midreset_missing: got %0d pending events required 0", exp_q.size()); exp_q.delete(); end
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_long_press();
    test_glitch();
    test_release_on_long_edge();
    test_reset_mid_press();
    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
